hs_rr_merge: RTL

Parametrised single-clock valid/ready merge stage for the switching fabric. It accepts CHANNELS independent input streams, each with its own DEPTH-entry buffer, and merges them round-robin onto one registered valid/ready output tagged with the source channel. Per-channel ordering is preserved and the output sustains one beat per cycle. It sits downstream of the per-port clock-domain handshakes, where all ports share the switch core clock.

---
 rtl/hs_rr_merge.sv | 127 ++++++++++++
 1 files changed

// File: rtl/hs_rr_merge.sv
// hs_rr_merge: CHANNELS buffered valid/ready inputs merged round-robin onto one
// registered output. Each output beat is tagged with its source channel.

// Per-channel circular buffer. Read data is taken combinationally at rd_ptr.
module hs_rr_merge_fifo #(
  parameter int DATA_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty,
  output logic                  full
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
endmodule

module hs_rr_merge #(
  parameter int DATA_WIDTH = 5,
  parameter int CHANNELS   = 4,
  parameter int DEPTH      = 4,
  localparam int CH_W      = $clog2(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS-1:0]            in_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]            in_ready,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [CH_W-1:0]                out_chan,
  input  logic                           out_ready
);
  logic [CHANNELS-1:0]                 push, pop, empty, full;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0] rdata;
  logic [CH_W-1:0]                     rr, grant, cand;
  logic                                found, load;
  int                                  idx;

  // Output register accepts a new beat when it is empty or being drained.
  assign load = !out_valid || out_ready;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    // in_ready comes from the registered count only: no push-through on full.
    assign in_ready[c] = !full[c];
    assign push[c]     = in_valid[c] && !full[c];
    assign pop[c]      = load && found && (grant == CH_W'(c));

    hs_rr_merge_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[c]),
      .pop   (pop[c]),
      .wdata (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .rdata (rdata[c]),
      .empty (empty[c]),
      .full  (full[c])
    );
  end

  // Round-robin search starting at rr; first non-empty channel wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    cand  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = int'(rr) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      cand = CH_W'(idx);
      if (!found && !empty[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  // Output register and arbiter pointer; rr advances past the granted channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr        <= '0;
    end else if (load) begin
      out_valid <= found;
      if (found) begin
        out_data <= rdata[grant];
        out_chan <= grant;
        rr       <= (grant == CH_W'(CHANNELS-1)) ? '0 : grant + 1'b1;
      end
    end
  end
endmodule
